mac4_dot_acc: RTL

Sequential dot-product stage built around the existing 4x4 array multiplier. Accepts a stream of 4-bit operand pairs over a valid/ready handshake and registers each 8-bit product. Accumulates N_TERMS products into one unsigned sum and presents the sum on a valid/ready output port. Sits directly downstream of the operand source and drives the product of the array multiplier into an accumulator, turning the combinational multiplier into a pipelined MAC unit.

---
 rtl/mac4_dot_acc_pkg.sv | 25 ++
 rtl/mac4_dot_acc_if.sv | 26 ++
 rtl/mac4_dot_acc_mult.sv | 34 +++
 rtl/mac4_dot_acc.sv | 119 +++++++++++
 4 files changed

// File: rtl/mac4_dot_acc_pkg.sv
// Shared definitions for the mac4_dot_acc dot-product stage: operand/product widths,
// FSM encoding and the bit-level helpers used by the array multiplier.
package mac4_dot_acc_pkg;

    localparam int OPND_W   = 4;
    localparam int PROD_W   = 8;
    localparam int MAX_PROD = 225;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    // Returns {carry, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
        full_add = {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
    endfunction

    // Narrowest accumulator that can hold n worst-case products without wrapping.
    function automatic int acc_w_min(input int n);
        acc_w_min = $clog2(MAX_PROD * n + 1);
    endfunction

endpackage

// File: rtl/mac4_dot_acc_if.sv
// Operand input and result output handshakes of mac4_dot_acc bundled as one interface.
interface mac4_dot_acc_if
    import mac4_dot_acc_pkg::*;
#(
    parameter int ACC_W = 12
) ();

    logic              in_valid;
    logic              in_ready;
    logic [OPND_W-1:0] x;
    logic [OPND_W-1:0] y;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  acc_out;

    modport master (
        output in_valid, x, y, out_ready,
        input  in_ready, out_valid, acc_out
    );

    modport slave (
        input  in_valid, x, y, out_ready,
        output in_ready, out_valid, acc_out
    );

endinterface

// File: rtl/mac4_dot_acc_mult.sv
// Combinational 4x4 unsigned array multiplier: one ripple row of full adders per
// multiplier bit, each row folding its shifted partial product into the running sum.
module mac4_dot_acc_mult
    import mac4_dot_acc_pkg::*;
(
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic [PROD_W-1:0] p
);

    logic [PROD_W-1:0] part_s;
    logic              carry_s;
    logic [1:0]        fa_s;

    // Row r only touches bits r..r+OPND_W; everything above is still zero, so the
    // row carry-out lands directly in bit r+OPND_W.
    always_comb begin
        part_s  = {PROD_W{1'b0}};
        carry_s = 1'b0;
        fa_s    = 2'b00;
        for (int r = 0; r < OPND_W; r++) begin
            carry_s = 1'b0;
            for (int c = 0; c < OPND_W; c++) begin
                fa_s          = full_add(part_s[r + c], a[c] & b[r], carry_s);
                part_s[r + c] = fa_s[0];
                carry_s       = fa_s[1];
            end
            part_s[r + OPND_W] = carry_s;
        end
    end

    assign p = part_s;

endmodule

// File: rtl/mac4_dot_acc.sv
// mac4_dot_acc: pipelined MAC that multiplies accepted 4-bit pairs, sums N_TERMS
// products and holds the sum on a valid/ready output until it is consumed.
module mac4_dot_acc
    import mac4_dot_acc_pkg::*;
#(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    mac4_dot_acc_if.slave bus
);

    localparam int CNT_W = $clog2(N_TERMS + 1);

    if (N_TERMS < 1 || N_TERMS > 16) begin : g_bad_n_terms
        $error("mac4_dot_acc: N_TERMS must be in 1..16");
    end
    if (ACC_W < acc_w_min(N_TERMS)) begin : g_bad_acc_w
        $error("mac4_dot_acc: ACC_W too narrow for N_TERMS worst-case sum");
    end

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  term_add_q, term_add_d;
    logic [PROD_W-1:0] p_q, p_d;
    logic              p_vld_q, p_vld_d;
    logic [ACC_W-1:0]  acc_q, acc_d;

    logic [PROD_W-1:0] prod_s;
    logic              in_ready_s;
    logic              accept_s;

    mac4_dot_acc_mult u_mult (
        .a (bus.x),
        .b (bus.y),
        .p (prod_s)
    );

    assign in_ready_s = (state_q == ST_ACCUM);
    assign accept_s   = bus.in_valid && in_ready_s;

    // Next-state, counter and datapath logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        term_add_d = term_add_q;
        p_d        = p_q;
        p_vld_d    = 1'b0;
        acc_d      = acc_q;

        if (accept_s) begin
            p_d     = prod_s;
            p_vld_d = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
        end else begin
            p_d = p_q;
        end

        if (p_vld_q) begin
            acc_d      = acc_q + ACC_W'(p_q);
            term_add_d = term_add_q + CNT_W'(1);
        end else begin
            acc_d = acc_q;
        end

        case (state_q)
            ST_ACCUM: begin
                // Comparing the pre-increment count also covers N_TERMS == 1.
                if (accept_s && (cnt_q == CNT_W'(N_TERMS - 1))) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_DRAIN: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    state_d    = ST_ACCUM;
                    acc_d      = {ACC_W{1'b0}};
                    cnt_d      = {CNT_W{1'b0}};
                    term_add_d = {CNT_W{1'b0}};
                    p_vld_d    = 1'b0;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ACCUM;
            cnt_q      <= {CNT_W{1'b0}};
            term_add_q <= {CNT_W{1'b0}};
            p_q        <= {PROD_W{1'b0}};
            p_vld_q    <= 1'b0;
            acc_q      <= {ACC_W{1'b0}};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            term_add_q <= term_add_d;
            p_q        <= p_d;
            p_vld_q    <= p_vld_d;
            acc_q      <= acc_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.acc_out   = acc_q;

endmodule
